ram_pattern_wr: RTL

Parametrised write-side pattern generator for the simple dual-port RAM test path. On a start command it fills the RAM (addresses 0..DEPTH-1, one word per clock) with a selectable data pattern. It raises a sticky read-enable flag to the read-side block once a programmable number of words is written, and optionally loops continuously with a pass counter. It replaces the fixed 64×8 increment-only writer in the 2-port RAM demo.

---
 rtl/ram_pattern_wr.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_pattern_wr.sv
// Write-side pattern generator for the dual-port RAM test path.
// Fills addresses 0..DEPTH-1 with a selectable pattern, flags the reader once
// RD_THRESH words are written, and can loop continuously while counting passes.
module ram_pattern_wr #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RD_THRESH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rd_flag,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FlagAddr = ADDR_W'(RD_THRESH - 1);

  // Pattern value for address a under pattern m with seed s.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] res;
    int unsigned       rot;
    rot = 32'(a) % DATA_W;
    case (m)
      2'd0:    res = DATA_W'(a);
      2'd1:    res = s;
      // rot == 0 shifts the right half by the full width, which yields zero
      2'd2:    res = (s << rot) | (s >> (DATA_W - rot));
      default: res = a[0] ? ~s : s;
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                cont_q, cont_d;
  logic                rd_flag_q, rd_flag_d;
  logic                done_q, done_d;
  logic [15:0]         pass_cnt_q, pass_cnt_d;

  logic                accept;
  logic                last;
  logic [ADDR_W-1:0]   next_addr;

  assign accept    = (state_q == StIdle) && start && !abort;
  assign last      = (addr_q == LastAddr);
  assign next_addr = last ? '0 : addr_q + ADDR_W'(1);

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      cont_q     <= 1'b0;
      rd_flag_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      cont_q     <= cont_d;
      rd_flag_q  <= rd_flag_d;
      done_q     <= done_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  // Next state: abort wins over start in IDLE and ends a run in WRITE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWrite;
      StWrite: if (abort || (last && !cont_q)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: address/data stepping, flag, pass counter, done pulse.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    cont_d     = cont_q;
    rd_flag_d  = rd_flag_q;
    pass_cnt_d = pass_cnt_q;
    done_d     = 1'b0;
    if (accept) begin
      mode_d     = mode;
      seed_d     = seed;
      cont_d     = cont;
      rd_flag_d  = 1'b0;
      pass_cnt_d = '0;
      addr_d     = '0;
      data_d     = pattern(mode, seed, '0);
    end else if (state_q == StWrite) begin
      // The word presented this cycle is written even when aborting.
      if (addr_q == FlagAddr) rd_flag_d = 1'b1;
      if (abort) begin
        addr_d = '0;
        data_d = '0;
      end else begin
        if (last) begin
          pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
          done_d     = !cont_q;
        end
        if (last && !cont_q) begin
          addr_d = '0;
          data_d = '0;
        end else begin
          addr_d = next_addr;
          data_d = pattern(mode_q, seed_q, next_addr);
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy        = (state_q == StWrite);
    ram_wr_en   = busy;
    ram_wr_we   = busy;
    ram_wr_addr = addr_q;
    ram_wr_data = data_q;
    rd_flag     = rd_flag_q;
    done        = done_q;
    pass_cnt    = pass_cnt_q;
  end

endmodule
